wb_trig_sched: RTL and testbench

Wishbone-controlled sequencer for the trigger engine. It holds a 4-entry program of trigger configurations (`t_sel1`, `t_sel2`) and drives them into `trigger_top` one step at a time. Each step is advanced by a rising edge of the engine's `trig_o` or ended by a per-step timeout. It sits between the CPU Wishbone bus and `trigger_top`, so software can run multi-stage trigger conditions without polling each stage.

---
 rtl/wb_trig_sched_if.sv | 31 +++
 rtl/wb_trig_sched.sv | 196 +++++++++++++++++++
 tb/tb_wb_trig_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_trig_sched_if.sv
// ---------------------------------------------------------------------------
// wb_trig_sched_if
// Wishbone slave bundle for the trigger sequencer.
//   wb_stb_i / wb_cyc_i : strobe and cycle from the CPU
//   wb_we_i             : write enable
//   wb_adr_i            : byte address (only [4:2] decoded by the slave)
//   wb_sel_i            : byte selects (not used by the slave)
//   wb_dat_i            : write data
//   wb_ack_o            : acknowledge from the slave
//   wb_dat_o            : registered read data from the slave
// ---------------------------------------------------------------------------
interface wb_trig_sched_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/wb_trig_sched.sv
// ---------------------------------------------------------------------------
// wb_trig_sched
// Wishbone-programmed sequencer that walks the trigger engine through up to
// four select configurations, advancing on each rising edge of the engine's
// trigger output or ending on a per-step timeout.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   wb       : Wishbone slave port (CTRL, STATUS, TIMEOUT, STEP0..3)
//   trig_i   : trig_o of the trigger engine
//   t_sel1_o : engine select 1 for the current step
//   t_sel2_o : engine select 2 for the current step
//   clr_o    : engine clear, high in IDLE and CLEAR
//   irq_o    : level interrupt raised when a sequence finishes
// ---------------------------------------------------------------------------
module wb_trig_sched #(
    parameter int STEPS = 4
) (
    input  logic             clk,
    input  logic             reset,
    wb_trig_sched_if.slave   wb,
    input  logic             trig_i,
    output logic [3:0]       t_sel1_o,
    output logic [3:0]       t_sel2_o,
    output logic             clr_o,
    output logic             irq_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state, state_n;
    logic [1:0]  step, step_n;
    logic [7:0]  count, count_n;
    logic        done_r, done_n;
    logic        tmo_r, tmo_n;
    logic        loop_r;
    logic [1:0]  last_r;
    logic [15:0] timeout_r;
    logic [15:0] timer;
    logic [7:0]  step_mem [STEPS];
    logic        trig_q;
    logic        ack_r;
    logic [31:0] dat_r;
    logic [31:0] rdata;

    logic        acc, wr, rd;
    logic [2:0]  adr;
    logic        ctrl_wr, start, stop, start_ok;
    logic        trig_edge, expire, busy;
    logic        unused_bits;

    // A bus access is recognised on the first strobed cycle only; ack_r then
    // blocks a second recognition so every access is exactly two cycles.
    assign acc      = wb.wb_stb_i & wb.wb_cyc_i & ~ack_r;
    assign wr       = acc & wb.wb_we_i;
    assign rd       = acc & ~wb.wb_we_i;
    assign adr      = wb.wb_adr_i[4:2];
    assign ctrl_wr  = wr && (adr == 3'd0);
    assign stop     = ctrl_wr & wb.wb_dat_i[1];
    assign start    = ctrl_wr & wb.wb_dat_i[0] & ~wb.wb_dat_i[1];
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    assign trig_edge = trig_i & ~trig_q;
    // A loaded value of 0 never reaches 1, so a zero TIMEOUT disables expiry.
    assign expire    = (timer == 16'd1);
    assign busy      = (state == CLEAR) || (state == WAIT);

    assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_r;
    assign wb.wb_dat_o = dat_r;

    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0],
                           wb.wb_dat_i[31:16]};

    // Sequencer next-state decision. Stop overrides everything; in WAIT a
    // trigger edge takes priority over a simultaneous timer expiry.
    always_comb begin
        state_n = state;
        step_n  = step;
        count_n = count;
        done_n  = done_r;
        tmo_n   = tmo_r;
        if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n = CLEAR;
                        step_n  = 2'd0;
                        count_n = 8'd0;
                        done_n  = 1'b0;
                        tmo_n   = 1'b0;
                    end
                end
                CLEAR: state_n = WAIT;
                WAIT: begin
                    if (trig_edge) begin
                        count_n = count + 8'd1;
                        if (step < last_r) begin
                            step_n  = step + 2'd1;
                            state_n = CLEAR;
                        end else if (loop_r) begin
                            step_n  = 2'd0;
                            state_n = CLEAR;
                        end else begin
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
                    end else if (expire) begin
                        tmo_n   = 1'b1;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Register read multiplexer; CTRL reads back only its persistent fields.
    always_comb begin
        rdata = 32'd0;
        case (adr)
            3'd0: rdata = {26'd0, last_r, 1'b0, loop_r, 2'b00};
            3'd1: rdata = {16'd0, count, 2'b00, step, 1'b0, tmo_r, done_r, busy};
            3'd2: rdata = {16'd0, timeout_r};
            3'd3: rdata = 32'd0;
            default: rdata = {24'd0, step_mem[adr[1:0]]};
        endcase
    end

    // Bus side: acknowledge, registered read data and configuration writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_r     <= 1'b0;
            dat_r     <= 32'd0;
            loop_r    <= 1'b0;
            last_r    <= 2'd0;
            timeout_r <= 16'd0;
            for (int i = 0; i < STEPS; i++) step_mem[i] <= 8'd0;
        end else begin
            ack_r <= acc;
            if (rd) dat_r <= rdata;
            if (ctrl_wr) begin
                loop_r <= wb.wb_dat_i[2];
                last_r <= wb.wb_dat_i[5:4];
            end
            if (wr && (adr == 3'd2)) timeout_r <= wb.wb_dat_i[15:0];
            if (wr && adr[2]) step_mem[adr[1:0]] <= wb.wb_dat_i[7:0];
        end
    end

    // Sequencer state, step timer and the registered engine-facing outputs.
    // Selects are refreshed while idle and on entry to / during CLEAR, and
    // frozen through WAIT and DONE, so STEP writes never change a live step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= 2'd0;
            count    <= 8'd0;
            done_r   <= 1'b0;
            tmo_r    <= 1'b0;
            timer    <= 16'd0;
            trig_q   <= 1'b0;
            t_sel1_o <= 4'd0;
            t_sel2_o <= 4'd0;
            clr_o    <= 1'b1;
            irq_o    <= 1'b0;
        end else begin
            state  <= state_n;
            step   <= step_n;
            count  <= count_n;
            done_r <= done_n;
            tmo_r  <= tmo_n;
            trig_q <= trig_i;
            if (state == CLEAR) begin
                timer <= timeout_r;
            end else if ((state == WAIT) && (timer != 16'd0)) begin
                timer <= timer - 16'd1;
            end
            if ((state_n == IDLE) || (state_n == CLEAR) || (state == CLEAR)) begin
                t_sel1_o <= step_mem[step_n][3:0];
                t_sel2_o <= step_mem[step_n][7:4];
            end
            clr_o <= (state_n == IDLE) || (state_n == CLEAR);
            if (done_n & ~done_r) begin
                irq_o <= 1'b1;
            end else if (start_ok || (rd && (adr == 3'd1))) begin
                irq_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_trig_sched.sv
// ---------------------------------------------------------------------------
// tb_wb_trig_sched
// Self-checking bench for wb_trig_sched: register access vectors from a
// table, then hand-written sequences for stepping, timeout, looping, the
// trigger/timeout race, start-while-busy and reset mid-sequence.
// ---------------------------------------------------------------------------
module tb_wb_trig_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       trig_i;
    logic [3:0] t_sel1_o;
    logic [3:0] t_sel2_o;
    logic       clr_o;
    logic       irq_o;

    wb_trig_sched_if bus ();

    wb_trig_sched #(.STEPS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb       (bus),
        .trig_i   (trig_i),
        .t_sel1_o (t_sel1_o),
        .t_sel2_o (t_sel2_o),
        .clr_o    (clr_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wrAdr;
        logic [31:0] wrData;
        logic [31:0] rdAdr;
        logic [31:0] expRead;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t        expQ[$];
    vec_t        vecs[6];
    int          checks   = 0;
    int          failures = 0;
    logic        clrAtAck;
    logic [7:0]  selAtAck;
    logic        clrMid;
    logic        irqMid;
    logic [7:0]  selMid;
    logic [31:0] rdWord;
    logic        gotAck;
    logic [7:0]  stepVals [3];

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One Wishbone access; checks the two-cycle handshake and captures the
    // read data plus the engine outputs seen during the ack cycle.
    task automatic applyStimulus(input logic [31:0] adr, input logic we,
                                 input logic [31:0] data,
                                 output logic [31:0] rdata, output logic got);
        int waits;
        got   = 1'b0;
        rdata = 32'd0;
        waits = 0;
        @(posedge clk);
        #1;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_sel_i = 4'hF;
        bus.wb_dat_i = data;
        while (!got && waits < 4) begin
            @(negedge clk);
            waits++;
            if (bus.wb_ack_o) begin
                got      = 1'b1;
                rdata    = bus.wb_dat_o;
                clrAtAck = clr_o;
                selAtAck = {t_sel2_o, t_sel1_o};
            end
        end
        if (!got) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("ack_latency", 32'(waits), 32'd2);
            @(posedge clk);
            #1;
            checkOutput("ack_drop", {31'd0, bus.wb_ack_o}, 32'd0);
        end
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic writeReg(input logic [31:0] adr, input logic [31:0] data);
        logic [31:0] unusedRd;
        logic        got;
        applyStimulus(adr, 1'b1, data, unusedRd, got);
    endtask

    // Reads go through the scoreboard: expectation queued, popped on ack.
    task automatic readCheck(input logic [31:0] adr, input logic [31:0] expected,
                             input string name);
        exp_t e;
        e.name  = name;
        e.value = expected;
        expQ.push_back(e);
        applyStimulus(adr, 1'b0, 32'd0, rdWord, gotAck);
        e = expQ.pop_front();
        if (gotAck) checkOutput(e.name, rdWord, e.value);
    endtask

    // Raise trig_i so its rising edge lands on the next clock edge; sample
    // the engine outputs in the cycle right after that edge.
    task automatic pulseTrig();
        @(posedge clk);
        #1 trig_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clrMid = clr_o;
        irqMid = irq_o;
        selMid = {t_sel2_o, t_sel1_o};
        @(posedge clk);
        #1 trig_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{32'h08, 32'h1234ABCD, 32'h08, 32'h0000ABCD, "timeout_rw"};
        vecs[1] = '{32'h10, 32'hFFFFFFFF, 32'h10, 32'h000000FF, "step0_rw"};
        vecs[2] = '{32'h3C, 32'h0000005A, 32'h1C, 32'h0000005A, "step3_alias"};
        vecs[3] = '{32'h0C, 32'hFFFFFFFF, 32'h0C, 32'h00000000, "reg3_ignored"};
        vecs[4] = '{32'h00, 32'h000000FF, 32'h00, 32'h00000034, "ctrl_stop_wins"};
        vecs[5] = '{32'h24, 32'h0000FFFF, 32'h04, 32'h00000000, "status_ro_idle"};
        stepVals[0] = 8'h21;
        stepVals[1] = 8'h43;
        stepVals[2] = 8'h65;

        reset        = 1'b1;
        trig_i       = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'd0;
        bus.wb_sel_i = 4'd0;
        bus.wb_dat_i = 32'd0;

        $display("[TB] reset values");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        checkOutput("rst_dat", bus.wb_dat_o, 32'd0);
        checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
        checkOutput("rst_clr", {31'd0, clr_o}, 32'd1);
        checkOutput("rst_sel", {24'd0, t_sel2_o, t_sel1_o}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        readCheck(32'h04, 32'h0, "status_reset");

        $display("[TB] register vectors");
        for (int i = 0; i < 6; i++) begin
            writeReg(vecs[i].wrAdr, vecs[i].wrData);
            readCheck(vecs[i].rdAdr, vecs[i].expRead, vecs[i].name);
        end

        $display("[TB] two-step sequence");
        writeReg(32'h08, 32'd0);
        writeReg(32'h10, 32'h21);
        writeReg(32'h14, 32'h43);
        writeReg(32'h00, 32'h11);
        checkOutput("start_clear", {31'd0, clrAtAck}, 32'd1);
        checkOutput("start_sel", {24'd0, selAtAck}, 32'h21);
        checkOutput("start_wait_clr", {31'd0, clr_o}, 32'd0);
        pulseTrig();
        checkOutput("step1_clear", {31'd0, clrMid}, 32'd1);
        checkOutput("step1_sel", {24'd0, selMid}, 32'h43);
        @(negedge clk);
        checkOutput("step1_wait_clr", {31'd0, clr_o}, 32'd0);
        pulseTrig();
        checkOutput("done_irq", {31'd0, irqMid}, 32'd1);
        checkOutput("done_clr", {31'd0, clrMid}, 32'd0);
        checkOutput("done_sel", {24'd0, selMid}, 32'h43);
        readCheck(32'h04, 32'h0212, "status_done");
        checkOutput("irq_cleared", {31'd0, irq_o}, 32'd0);
        readCheck(32'h04, 32'h0212, "status_done_kept");

        $display("[TB] timeout");
        writeReg(32'h08, 32'd5);
        writeReg(32'h00, 32'h01);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (irq_o) break;
            n++;
        end
        checkOutput("timeout_cycles", 32'(n), 32'd5);
        readCheck(32'h04, 32'h06, "status_timeout");
        checkOutput("timeout_irq_cleared", {31'd0, irq_o}, 32'd0);

        $display("[TB] looping");
        writeReg(32'h08, 32'd0);
        writeReg(32'h18, 32'h65);
        writeReg(32'h00, 32'h25);
        for (int i = 1; i <= 7; i++) begin
            pulseTrig();
            checkOutput("loop_sel", {24'd0, selMid}, {24'd0, stepVals[i % 3]});
        end
        readCheck(32'h04, 32'h0711, "status_loop");
        writeReg(32'h00, 32'h02);
        checkOutput("stop_clr", {31'd0, clr_o}, 32'd1);
        checkOutput("stop_sel", {24'd0, t_sel2_o, t_sel1_o}, 32'h43);
        readCheck(32'h04, 32'h0710, "status_stopped");

        $display("[TB] trigger and timeout on the same edge");
        writeReg(32'h08, 32'd20);
        writeReg(32'h00, 32'h11);
        repeat (18) @(posedge clk);
        pulseTrig();
        checkOutput("race_clear", {31'd0, clrMid}, 32'd1);
        checkOutput("race_sel", {24'd0, selMid}, 32'h43);
        readCheck(32'h04, 32'h0111, "status_race");
        writeReg(32'h00, 32'h11);
        readCheck(32'h04, 32'h0111, "status_busy_start");
        checkOutput("busy_irq", {31'd0, irq_o}, 32'd0);

        $display("[TB] reset mid-sequence");
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst_clr", {31'd0, clr_o}, 32'd1);
        checkOutput("midrst_sel", {24'd0, t_sel2_o, t_sel1_o}, 32'd0);
        checkOutput("midrst_irq", {31'd0, irq_o}, 32'd0);
        checkOutput("midrst_dat", bus.wb_dat_o, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        readCheck(32'h04, 32'h0, "status_after_rst");
        readCheck(32'h10, 32'h0, "step0_after_rst");
        readCheck(32'h08, 32'h0, "timeout_after_rst");

        checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
